// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared bf16 constants and divider state encoding
package fpu_pkg;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [15:0] BF16_INF  = 16'h7F80;
    localparam int          BF16_BIAS = 127;
    localparam int          DIV_ITERS = 10;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        ROUND
    } div_state_t;

endpackage

// File: rtl/bf16_classify.sv
// rtl/bf16_classify.sv - combinational zero/inf/nan classification of one bf16 operand
module bf16_classify
    import fpu_pkg::*;
(
    input  logic [15:0] operand,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);

    logic [7:0] exp_f;
    logic [6:0] man_f;

    assign exp_f = operand[14:7];
    assign man_f = operand[6:0];

    // Denormals have a zero exponent field and are treated as zero.
    assign is_zero = (exp_f == 8'h00);
    assign is_inf  = (exp_f == 8'hFF) && (man_f == 7'h00);
    assign is_nan  = (exp_f == 8'hFF) && (man_f != 7'h00);

endmodule

// File: rtl/fdiv_seq.sv
// rtl/fdiv_seq.sv - multi-cycle bf16 divider, restoring mantissa division one bit per cycle
module fdiv_seq
    import fpu_pkg::*;
#(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

    div_state_t  state;
    logic        sign_r;
    logic [7:0]  ea_r;
    logic [7:0]  eb_r;
    logic [7:0]  mb_r;
    logic [8:0]  rem;
    logic [9:0]  q;
    logic [3:0]  cnt;

    logic zero_a, inf_a, nan_a;
    logic zero_b, inf_b, nan_b;

    bf16_classify u_class_a (
        .operand (a_in),
        .is_zero (zero_a),
        .is_inf  (inf_a),
        .is_nan  (nan_a)
    );

    bf16_classify u_class_b (
        .operand (b_in),
        .is_zero (zero_b),
        .is_inf  (inf_b),
        .is_nan  (nan_b)
    );

    logic        s_in;
    logic        special_hit;
    logic [15:0] special_val;

    always_comb begin
        s_in        = a_in[15] ^ b_in[15];
        special_hit = 1'b1;
        special_val = BF16_QNAN;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            special_val = BF16_QNAN;
        end else if (inf_a || zero_b) begin
            special_val = {s_in, BF16_INF[14:0]};
        end else if (zero_a || inf_b) begin
            special_val = {s_in, 15'h0000};
        end else begin
            special_hit = 1'b0;
        end
    end

    logic       rem_ge;
    logic [8:0] rem_sub;
    logic [8:0] rem_next;

    always_comb begin
        rem_ge   = (rem >= {1'b0, mb_r});
        rem_sub  = rem_ge ? (rem - {1'b0, mb_r}) : rem;
        rem_next = rem_sub << 1;
    end

    logic [9:0]  e_raw;
    logic [9:0]  e_adj;
    logic [6:0]  man7;
    logic        guard;
    logic [7:0]  man_sum;
    logic [6:0]  man_fin;
    logic [15:0] packed_res;

    always_comb begin
        // A quotient below 1.0 (q[9] clear) costs one exponent step.
        e_raw = {2'b00, ea_r} - {2'b00, eb_r} + 10'(BF16_BIAS) - {9'b0, ~q[9]};
        if (q[9]) begin
            man7  = q[8:2];
            guard = q[1];
        end else begin
            man7  = q[7:1];
            guard = q[0];
        end
        man_sum = {1'b0, man7} + {7'b0, guard & ROUND_EN};
        e_adj   = e_raw + {9'b0, man_sum[7]};
        man_fin = man_sum[7] ? 7'h00 : man_sum[6:0];
        if ($signed(e_adj) >= 10'sd255) begin
            packed_res = {sign_r, 8'hFF, 7'h00};
        end else if ($signed(e_adj) <= 10'sd0) begin
            packed_res = {sign_r, 15'h0000};
        end else begin
            packed_res = {sign_r, e_adj[7:0], man_fin};
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sign_r <= 1'b0;
            ea_r   <= 8'h00;
            eb_r   <= 8'h00;
            mb_r   <= 8'h00;
            rem    <= 9'h000;
            q      <= 10'h000;
            cnt    <= 4'h0;
            done   <= 1'b0;
            result <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_r <= s_in;
                        ea_r   <= a_in[14:7];
                        eb_r   <= b_in[14:7];
                        mb_r   <= {1'b1, b_in[6:0]};
                        rem    <= {2'b01, a_in[6:0]};
                        q      <= 10'h000;
                        cnt    <= 4'h0;
                        if (special_hit) begin
                            result <= special_val;
                            done   <= 1'b1;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    q   <= {q[8:0], rem_ge};
                    rem <= rem_next;
                    if (cnt == 4'(DIV_ITERS - 1)) begin
                        cnt   <= 4'h0;
                        state <= ROUND;
                    end else begin
                        cnt <= cnt + 4'h1;
                    end
                end
                ROUND: begin
                    result <= packed_res;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// tb/tb_fdiv_seq.sv - self-checking bench for fdiv_seq against an arithmetic bf16 division model
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_in = 16'h0000;
    logic [15:0] b_in = 16'h0000;
    logic        busy, done;
    logic [15:0] result;
    logic        busy_t, done_t;
    logic [15:0] result_t;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fdiv_seq #(.ROUND_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result(result)
    );

    fdiv_seq #(.ROUND_EN(1'b0)) dut_t (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy_t), .done(done_t), .result(result_t)
    );

    function automatic bit model_special(input logic [15:0] a, input logic [15:0] b);
        bit za, zb, ia, ib;
        za = (a[14:7] == 8'h00);
        zb = (b[14:7] == 8'h00);
        ia = (a[14:7] == 8'hFF);
        ib = (b[14:7] == 8'hFF);
        return za || zb || ia || ib;
    endfunction

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b, input bit rnd);
        bit s, za, zb, ia, ib, na, nb;
        int ea, eb, ma, mb, qv, e, man, g;
        logic [15:0] r;
        s  = a[15] ^ b[15];
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[6:0] == 7'h0);
        ib = (eb == 255) && (b[6:0] == 7'h0);
        na = (ea == 255) && (a[6:0] != 7'h0);
        nb = (eb == 255) && (b[6:0] != 7'h0);
        if (na || nb || (za && zb) || (ia && ib)) return 16'h7FC0;
        if (ia || zb) return {s, 15'h7F80};
        if (za || ib) return {s, 15'h0000};
        ma = 128 + int'(a[6:0]);
        mb = 128 + int'(b[6:0]);
        qv = (ma * 512) / mb;
        e  = ea - eb + 127;
        if (qv >= 512) begin
            man = (qv - 512) / 4;
            g   = ((qv - 512) / 2) % 2;
        end else begin
            e   = e - 1;
            man = (qv - 256) / 2;
            g   = qv % 2;
        end
        if (rnd) man = man + g;
        if (man == 128) begin
            man = 0;
            e   = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 7'h00};
        if (e <= 0) return {s, 15'h0000};
        r = {s, e[7:0], man[6:0]};
        return r;
    endfunction

    // Drives one start pulse and follows both instances to their done pulse.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r1, output logic [15:0] r0,
                          output int lat, output int busy_cnt);
        bit got1, got0;
        got1 = 1'b0; got0 = 1'b0;
        r1 = 16'h0; r0 = 16'h0; lat = -1; busy_cnt = 0;
        a_in = a; b_in = b; start = 1'b1;
        for (int i = 1; i <= 40 && !(got1 && got0); i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            a_in = 16'($urandom);
            b_in = 16'($urandom);
            if (busy) busy_cnt++;
            if (done && !got1) begin got1 = 1'b1; lat = i; r1 = result; end
            if (done_t && !got0) begin got0 = 1'b1; r0 = result_t; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b result=%h expected 0 0 0000", busy, done, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] r1, r0;
        int lat, bc;
        run_op(16'h40C0, 16'h4000, r1, r0, lat, bc);
        total++;
        if (r1 !== 16'h4040 || r0 !== 16'h4040) begin
            bad++; $display("FAIL six_by_two: got %h/%h expected 4040", r1, r0);
        end
        total++;
        if (lat !== 12) begin bad++; $display("FAIL latency: got %0d expected 12", lat); end
        total++;
        if (bc !== 11) begin bad++; $display("FAIL busy_cycles: got %0d expected 11", bc); end
        run_op(16'h3F80, 16'h4040, r1, r0, lat, bc);
        total++;
        if (r1 !== 16'h3EAB) begin bad++; $display("FAIL third_round: got %h expected 3EAB", r1); end
        total++;
        if (r0 !== 16'h3EAA) begin bad++; $display("FAIL third_trunc: got %h expected 3EAA", r0); end
    endtask

    task automatic test_specials();
        logic [15:0] ops [8][3];
        logic [15:0] r1, r0;
        int lat, bc;
        ops = '{'{16'h3F80, 16'h0000, 16'h7F80}, '{16'hBF80, 16'h0000, 16'hFF80},
                '{16'h0000, 16'h0000, 16'h7FC0}, '{16'h7F80, 16'h7F80, 16'h7FC0},
                '{16'h4000, 16'h7F80, 16'h0000}, '{16'h7F00, 16'h3F00, 16'h7F80},
                '{16'h0080, 16'h4300, 16'h0000}, '{16'hC000, 16'h4000, 16'hBF80}};
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i][0], ops[i][1], r1, r0, lat, bc);
            total++;
            if (r1 !== ops[i][2] || r0 !== ops[i][2]) begin
                bad++;
                $display("FAIL special_%0d: %h/%h got %h/%h expected %h",
                         i, ops[i][0], ops[i][1], r1, r0, ops[i][2]);
            end
            if (i < 5) begin
                total++;
                if (lat !== 1) begin
                    bad++; $display("FAIL special_lat_%0d: got %0d expected 1", i, lat);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, r1, r0, e1, e0;
        int lat, bc, exp_lat;
        for (int n = 0; n < 150; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 9) == 0) a[14:7] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            if ($urandom_range(0, 9) == 0) b[14:7] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            if ($urandom_range(0, 9) == 0) a[6:0] = 7'h00;
            e1 = model(a, b, 1'b1);
            e0 = model(a, b, 1'b0);
            exp_lat = model_special(a, b) ? 1 : 12;
            run_op(a, b, r1, r0, lat, bc);
            total++;
            if (r1 !== e1 || r0 !== e0 || lat !== exp_lat) begin
                bad++;
                $display("FAIL random: %h/%h got %h/%h lat %0d expected %h/%h lat %0d",
                         a, b, r1, r0, lat, e1, e0, exp_lat);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int pulses;
        logic [15:0] last;
        pulses = 0; last = 16'h0;
        a_in = 16'h40C0; b_in = 16'h4000; start = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk); #1;
            start = (i == 5);
            if (i == 5) begin a_in = 16'h3F80; b_in = 16'h4040; end
            if (done) begin pulses++; last = result; end
        end
        total++;
        if (pulses !== 1 || last !== 16'h4040) begin
            bad++; $display("FAIL start_while_busy: pulses=%0d result=%h expected 1 4040", pulses, last);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r1, r0;
        int lat, bc;
        a_in = 16'h3F80; b_in = 16'h4040; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h expected 0 0 0000", busy, done, result);
        end
        repeat (15) @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || result !== 16'h0000) begin
            bad++; $display("FAIL reset_abort: done=%b result=%h expected 0 0000", done, result);
        end
        run_op(16'h40C0, 16'h4000, r1, r0, lat, bc);
        total++;
        if (r1 !== 16'h4040 || lat !== 12) begin
            bad++; $display("FAIL after_reset: got %h lat %0d expected 4040 lat 12", r1, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_specials();
        test_random();
        test_start_while_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
